// File: rtl/mdu_core.sv
// Multiply/divide unit with HI/LO registers for the E stage.
// Accepts one operation per Start pulse, stays busy for a fixed latency, then commits.
module mdu_core #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             Start,
  input  logic [2:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MADD  = 3'd7;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_busy, w_busy_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [2:0]       r_op, w_op_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;

  logic signed [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0]        w_prod_u;
  logic [2*WIDTH-1:0]        w_madd;
  logic [WIDTH-1:0]          w_div_b;
  logic signed [WIDTH-1:0]   w_quo_s;
  logic signed [WIDTH-1:0]   w_rem_s;
  logic [WIDTH-1:0]          w_quo_u;
  logic [WIDTH-1:0]          w_rem_u;
  logic                      w_div_zero;
  logic                      w_div_ovf;

  // Arithmetic works only on latched operands so it is stable across the whole RUN phase.
  assign w_prod_s = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) * $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
  assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  assign w_madd   = {r_hi, r_lo} + $unsigned(w_prod_s);

  // A zero divisor is replaced by 1 so the dividers never produce X; the result is discarded anyway.
  assign w_div_zero = (r_b == '0);
  assign w_div_b    = w_div_zero ? WIDTH'(1) : r_b;
  assign w_div_ovf  = (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);
  assign w_quo_s    = $signed(r_a) / $signed(w_div_b);
  assign w_rem_s    = $signed(r_a) % $signed(w_div_b);
  assign w_quo_u    = r_a / w_div_b;
  assign w_rem_u    = r_a % w_div_b;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_NONE;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_op    <= w_op_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_op_nxt    = r_op;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (Start && (MDUOp != OP_NONE)) begin
          case (MDUOp)
            OP_MTHI: w_hi_nxt = A;
            OP_MTLO: w_lo_nxt = A;
            default: begin
              w_a_nxt     = A;
              w_b_nxt     = B;
              w_op_nxt    = MDUOp;
              w_cnt_nxt   = ((MDUOp == OP_DIV) || (MDUOp == OP_DIVU)) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
              w_state_nxt = S_RUN;
              w_busy_nxt  = 1'b1;
            end
          endcase
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          case (r_op)
            OP_MULT:  {w_hi_nxt, w_lo_nxt} = w_prod_s;
            OP_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
            OP_MADD:  {w_hi_nxt, w_lo_nxt} = w_madd;
            OP_DIV: begin
              if (!w_div_zero) begin
                if (w_div_ovf) begin
                  w_lo_nxt = r_a;
                  w_hi_nxt = '0;
                end else begin
                  w_lo_nxt = w_quo_s;
                  w_hi_nxt = w_rem_s;
                end
              end
            end
            OP_DIVU: begin
              if (!w_div_zero) begin
                w_lo_nxt = w_quo_u;
                w_hi_nxt = w_rem_u;
              end
            end
            default: ;
          endcase
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign Busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu_core.sv
// Bench for mdu_core: a 32-bit default instance and a 16-bit, single-cycle-multiply instance.
// Directed table, hand-written corner sequences, then random ops against an arithmetic model.
module tb_mdu_core;

  localparam int MC0 = 5;
  localparam int DC0 = 10;
  localparam int MC1 = 1;
  localparam int DC1 = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0, s1;
  logic [2:0]  op0, op1;
  logic [31:0] a0, b0, hi0, lo0;
  logic [15:0] a1, b1, hi1, lo1;
  logic        busy0, busy1;

  always #5 clk = ~clk;

  mdu_core u0 (
    .clk(clk), .RESET_N(rst_n), .Start(s0), .MDUOp(op0), .A(a0), .B(b0),
    .Busy(busy0), .HI(hi0), .LO(lo0)
  );

  mdu_core #(.WIDTH(16), .MULT_CYCLES(MC1), .DIV_CYCLES(DC1)) u1 (
    .clk(clk), .RESET_N(rst_n), .Start(s1), .MDUOp(op1), .A(a1), .B(b1),
    .Busy(busy1), .HI(hi1), .LO(lo1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          inst;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic get_busy(input int inst);
    return (inst == 0) ? busy0 : busy1;
  endfunction

  function automatic logic [31:0] get_hi(input int inst);
    return (inst == 0) ? hi0 : {16'h0, hi1};
  endfunction

  function automatic logic [31:0] get_lo(input int inst);
    return (inst == 0) ? lo0 : {16'h0, lo1};
  endfunction

  // Reference: plain 64-bit integer arithmetic on sign/zero-extended operands.
  task automatic ref_op(input int w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi_i, input logic [31:0] lo_i,
                        output logic [31:0] hi_o, output logic [31:0] lo_o, output int lat);
    longint    sa, sb, ua, ub, q, r;
    bit [63:0] mask, p;
    mask = (64'd1 << w) - 64'd1;
    ua   = longint'(a) & longint'(mask);
    ub   = longint'(b) & longint'(mask);
    sa   = ua[w-1] ? ua - (longint'(1) << w) : ua;
    sb   = ub[w-1] ? ub - (longint'(1) << w) : ub;
    hi_o = hi_i;
    lo_o = lo_i;
    lat  = 0;
    p    = 64'd0;
    case (op)
      3'd1: begin p = 64'(sa * sb); lat = (w == 32) ? MC0 : MC1; end
      3'd2: begin p = 64'(ua * ub); lat = (w == 32) ? MC0 : MC1; end
      3'd7: begin p = ((64'(hi_i) << w) | 64'(lo_i)) + 64'(sa * sb); lat = (w == 32) ? MC0 : MC1; end
      default: ;
    endcase
    if (op == 3'd1 || op == 3'd2 || op == 3'd7) begin
      lo_o = 32'(p & mask);
      hi_o = 32'((p >> w) & mask);
    end
    if (op == 3'd3 || op == 3'd4) begin
      lat = (w == 32) ? DC0 : DC1;
      if (ub != 0) begin
        q = (op == 3'd3) ? sa / sb : ua / ub;
        r = (op == 3'd3) ? sa % sb : ua % ub;
        lo_o = 32'(64'(q) & mask);
        hi_o = 32'(64'(r) & mask);
      end
    end
    if (op == 3'd5) hi_o = 32'(64'(a) & mask);
    if (op == 3'd6) lo_o = 32'(64'(a) & mask);
  endtask

  // Issue one request at the next edge, scramble operands afterwards, count busy cycles.
  task automatic do_op(input int inst, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int nb);
    @(negedge clk);
    if (inst == 0) begin s0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    else begin s1 = 1'b1; op1 = op; a1 = a[15:0]; b1 = b[15:0]; end
    @(negedge clk);
    s0 = 1'b0; s1 = 1'b0; op0 = 3'd0; op1 = 3'd0;
    a0 = $urandom; b0 = $urandom; a1 = 16'($urandom); b1 = 16'($urandom);
    nb = 0;
    while (get_busy(inst) && nb < 200) begin
      nb++;
      @(negedge clk);
    end
  endtask

  vec_t        vecs[$];
  logic [31:0] m_hi[2], m_lo[2], e_hi, e_lo;
  int          nb, lat;

  initial begin
    rst_n = 1'b0;
    s0 = 1'b0; s1 = 1'b0; op0 = 3'd0; op1 = 3'd0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    vecs.push_back('{0, 3'd5, 32'h12345678, 32'h0,        0,   32'h12345678, 32'h0});
    vecs.push_back('{0, 3'd1, 32'hFFFFFFFD, 32'h5,        MC0, 32'hFFFFFFFF, 32'hFFFFFFF1});
    vecs.push_back('{0, 3'd7, 32'h2,        32'h3,        MC0, 32'hFFFFFFFF, 32'hFFFFFFF7});
    vecs.push_back('{0, 3'd3, 32'hFFFFFFF9, 32'h2,        DC0, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{0, 3'd4, 32'hFFFFFFF9, 32'h2,        DC0, 32'h00000001, 32'h7FFFFFFC});
    vecs.push_back('{0, 3'd3, 32'h00001234, 32'h0,        DC0, 32'h00000001, 32'h7FFFFFFC});
    vecs.push_back('{0, 3'd3, 32'h80000000, 32'hFFFFFFFF, DC0, 32'h00000000, 32'h80000000});
    vecs.push_back('{0, 3'd6, 32'hCAFEBABE, 32'h0,        0,   32'h00000000, 32'hCAFEBABE});
    vecs.push_back('{1, 3'd2, 32'h0000FFFF, 32'h0000FFFF, MC1, 32'h0000FFFE, 32'h00000001});
    vecs.push_back('{1, 3'd3, 32'h0000FFF9, 32'h00000002, DC1, 32'h0000FFFF, 32'h0000FFFD});

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset busy0", 64'(busy0), 64'd0);
    check("reset hi0", 64'(hi0), 64'd0);
    check("reset lo0", 64'(lo0), 64'd0);
    check("reset busy1", 64'(busy1), 64'd0);
    check("reset hilo1", 64'({hi1, lo1}), 64'd0);

    foreach (vecs[i]) begin
      do_op(vecs[i].inst, vecs[i].op, vecs[i].a, vecs[i].b, nb);
      $display("vec %0d inst=%0d op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", i, vecs[i].inst, vecs[i].op,
               vecs[i].a, vecs[i].b, nb, get_hi(vecs[i].inst), get_lo(vecs[i].inst));
      check($sformatf("vec%0d busy", i), 64'(nb), 64'(vecs[i].exp_busy));
      check($sformatf("vec%0d hi", i), 64'(get_hi(vecs[i].inst)), 64'(vecs[i].exp_hi));
      check($sformatf("vec%0d lo", i), 64'(get_lo(vecs[i].inst)), 64'(vecs[i].exp_lo));
    end

    // Start with MDUOp=0 in IDLE must be ignored.
    do_op(0, 3'd0, 32'h11111111, 32'h22222222, nb);
    check("op0 busy", 64'(nb), 64'd0);
    check("op0 lo", 64'(lo0), 64'hCAFEBABE);

    // mtlo pulsed mid-RUN is dropped; LO holds the division result.
    @(negedge clk);
    s0 = 1'b1; op0 = 3'd3; a0 = 32'd100; b0 = 32'd7;
    @(negedge clk);
    s0 = 1'b0; op0 = 3'd0;
    @(negedge clk);
    s0 = 1'b1; op0 = 3'd6; a0 = 32'hDEADBEEF;
    @(negedge clk);
    s0 = 1'b0; op0 = 3'd0;
    nb = 3;
    while (busy0 && nb < 200) begin nb++; @(negedge clk); end
    $display("mid-run mtlo: busy=%0d hi=%h lo=%h", nb, hi0, lo0);
    check("midrun busy", 64'(nb), 64'(DC0 + 1));
    check("midrun lo", 64'(lo0), 64'd14);
    check("midrun hi", 64'(hi0), 64'd2);

    // Asynchronous reset in the third busy cycle of a multu discards the result.
    @(negedge clk);
    s0 = 1'b1; op0 = 3'd2; a0 = 32'hFFFFFFFF; b0 = 32'hFFFFFFFF;
    @(negedge clk);
    s0 = 1'b0; op0 = 3'd0;
    @(negedge clk);
    @(negedge clk);
    check("pre-reset busy", 64'(busy0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async busy", 64'(busy0), 64'd0);
    check("async hilo", 64'({hi0, lo0}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (MC0 + 2) @(negedge clk);
    $display("after reset: busy=%0d hi=%h lo=%h", busy0, hi0, lo0);
    check("no commit busy", 64'(busy0), 64'd0);
    check("no commit hilo", 64'({hi0, lo0}), 64'd0);
    check("reset hilo1 b", 64'({hi1, lo1}), 64'd0);

    m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
    for (int n = 0; n < 80; n++) begin
      int          inst;
      logic [2:0]  op;
      logic [31:0] a, b;
      inst = n % 2;
      op   = 3'($urandom_range(1, 7));
      a    = $urandom;
      b    = $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 9) == 0) begin
        a = (inst == 0) ? 32'h80000000 : 32'h00008000;
        b = 32'hFFFFFFFF;
      end
      if (inst == 1) begin a = a & 32'hFFFF; b = b & 32'hFFFF; end
      ref_op((inst == 0) ? 32 : 16, op, a, b, m_hi[inst], m_lo[inst], e_hi, e_lo, lat);
      m_hi[inst] = e_hi;
      m_lo[inst] = e_lo;
      do_op(inst, op, a, b, nb);
      $display("rnd %0d inst=%0d op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", n, inst, op, a, b, nb,
               get_hi(inst), get_lo(inst));
      check($sformatf("rnd%0d busy", n), 64'(nb), 64'(lat));
      check($sformatf("rnd%0d hi", n), 64'(get_hi(inst)), 64'(e_hi));
      check($sformatf("rnd%0d lo", n), 64'(get_lo(inst)), 64'(e_lo));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_core.md
# mdu_core

Parametrised multiply/divide unit with HI/LO registers for the E stage of the pipelined MIPS core. It accepts one operation per start pulse and latches its operands. It runs for a fixed, parameter-set number of cycles, during which `Busy` is high, then commits the result to HI/LO. Beyond plain mult/div it adds configurable operand width, configurable latencies, and signed multiply-accumulate (`madd`).

## Interface
- `WIDTH`, 32, operand and HI/LO width; allowed range 8..64.
- `MULT_CYCLES`, 5, busy cycles for mult, multu and madd; must be ≥1.
- `DIV_CYCLES`, 10, busy cycles for div and divu; must be ≥1.

- `clk`  in  1  Clock. One clock domain; all state changes on the rising edge.
- `RESET_N`  in  1  Asynchronous, active-low reset.
- `Start`  in  1  Operation request, sampled on the rising edge of `clk`.
- `MDUOp`  in  3  Operation code:
  - 0 = none, 1 = mult, 2 = multu, 3 = div, 4 = divu
  - 5 = mthi, 6 = mtlo, 7 = madd (signed accumulate)
- `A`  in  WIDTH  Operand rs, already forwarded.
- `B`  in  WIDTH  Operand rt, already forwarded.
- `Busy`  out  1  Registered. High while an operation is in flight.
- `HI`  out  WIDTH  HI register, read directly by mfhi.
- `LO`  out  WIDTH  LO register, read directly by mflo.

## Operation
- **States:**
  - `IDLE`: `Busy` = 0.
  - `RUN`: `Busy` = 1; a down-counter `cnt` is active.
- **Acceptance rule:** an edge with `Start`=1, `MDUOp`≠0 and state `IDLE` accepts the request. In every other case, `Start` is ignored entirely: no state change and no effect on HI/LO.
- **mthi / mtlo:** on acceptance, `HI` (or `LO`) ← `A` at that same edge. No `RUN` phase.
- **mult, multu, madd, div, divu:** on acceptance, the unit latches `A`, `B` and the opcode into internal registers, loads `cnt` with `MULT_CYCLES` or `DIV_CYCLES`, and enters `RUN`. Later changes on `A`/`B` have no effect.
- **RUN progression:** `cnt` decrements each edge. The edge at which `cnt`=1 commits the result, sets state to `IDLE` and clears `Busy`.
- **Arithmetic on commit (2·WIDTH-bit product):**
  - mult: {HI,LO} ← signed A×B.
  - multu: {HI,LO} ← unsigned A×B.
  - madd: {HI,LO} ← {HI,LO} + signed A×B, modulo 2^(2·WIDTH). HI/LO are taken at commit time.
  - div: LO ← quotient truncated toward zero; HI ← remainder, with the sign of the dividend.
  - divu: LO ← unsigned quotient; HI ← unsigned remainder.
- **Division corner cases:**
  - B = 0 (div or divu): HI and LO are unchanged, but the full `DIV_CYCLES` busy period still runs.
  - Signed overflow (A = −2^(WIDTH−1), B = −1): LO ← A, HI ← 0.
- **Stall-controller contract:** the controller stalls any MDU instruction in D while `Start`‖`Busy` holds for the instruction in E. This unit does not queue requests.
- **Reset:** `RESET_N`=0 at any time, including mid-`RUN`, immediately forces the following. The in-flight result is discarded.
  - state = `IDLE`, `Busy` = 0, `cnt` = 0
  - `HI` = 0, `LO` = 0, latched operands = 0

## Timing
- Let the request be accepted at edge t, and let N be the latency of the operation.
- `Busy` reads 1 in cycles t+1 … t+N.
- HI/LO get the new value at edge t+N. `Busy` reads 0 from cycle t+N+1.
- A new `Start` is accepted at the earliest at edge t+N+1. The unit has no back-to-back overlap.
- mthi/mtlo: the new value is visible in cycle t+1, and `Busy` never rises.
- A `Start` at an edge where `Busy`=1, including mthi/mtlo, is dropped.
- `RESET_N` deasserting between edges causes no spurious transition. The first acceptance can happen on the first rising edge with `RESET_N`=1.
- `HI`/`LO`/`Busy` are driven straight from flops. There is no combinational path from the inputs to the outputs.

## Test plan
- **Reset values:** reset, then release → `Busy`=0, HI=LO=0. Then mthi with A=0x12345678 → HI=0x12345678 in the next cycle, and `Busy` stays 0.
- **mult:** A=0xFFFFFFFD (−3), B=5 → `Busy` high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- **madd:** after the mult above, madd with A=2, B=3 → LO=0xFFFFFFF7, HI=0xFFFFFFFF.
- **Signed and unsigned division:**
  - div, A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu with the same operands → LO=0x7FFFFFFC, HI=0x00000001.
- **Division corner cases and ignored requests:**
  - div with B=0 → HI/LO unchanged after 10 busy cycles.
  - div with A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
  - Start(mtlo) pulsed mid-`RUN` → ignored; LO holds the committed division result.
- **Reset mid-operation, plus a second configuration:**
  - Assert `RESET_N`=0 at cycle 3 of a multu → `Busy`=0 and HI=LO=0 immediately; no commit follows.
  - Re-run with WIDTH=16, MULT_CYCLES=1: multu with A=0xFFFF, B=0xFFFF → `Busy` is high for 1 cycle, then HI=0xFFFE, LO=0x0001.
